// File: rtl/mem_arbiter_rr.sv
// -----------------------------------------------------------------------------
// mem_arbiter_rr
//
// Shares one single-port synchronous RAM between NUM_PORTS requesting cores.
// One operation is in flight at a time. A winner is picked in IDLE, its
// address, write data and write enable are registered onto the RAM bus, and
// the operation runs to completion. Completion is signalled by a one-cycle,
// one-hot pulse on acq. Read data is captured into that port's Dq slice and
// held there until the port completes another read.
//
// Arbitration
//   default                 : round-robin. The scan starts at the port after
//                             the last winner and wraps from NUM_PORTS-1 to 0.
//   MEMARB_FIXED_PRIO_EN    : fixed priority. The lowest requesting index wins
//                             and no last-grant pointer is kept.
//
// Parameters
//   NUM_PORTS  requesting cores, 2..8
//   ADDR_W     RAM address width
//   DATA_W     RAM data width
//   RD_LAT     RAM clock edges from address to valid q, 1 or 2
//
// Ports
//   CLK         in   system clock; all logic uses the rising edge
//   rst         in   asynchronous active-high reset
//   rden        in   [NUM_PORTS]         per-port read request
//   wren        in   [NUM_PORTS]         per-port write request (wins over rden)
//   Address     in   [NUM_PORTS*ADDR_W]  per-port address, port 0 in the LSBs
//   Din         in   [NUM_PORTS*DATA_W]  per-port write data, port 0 in the LSBs
//   RAMq        in   [DATA_W]            RAM read data
//   acq         out  [NUM_PORTS]         one-hot completion pulse
//   Dq          out  [NUM_PORTS*DATA_W]  per-port held read data
//   RAMAddress  out  [ADDR_W]            registered RAM address
//   RAMDin      out  [DATA_W]            registered RAM write data
//   RAMwren     out                      registered RAM write enable
// -----------------------------------------------------------------------------
module mem_arbiter_rr #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                          CLK,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          rden,
    input  logic [NUM_PORTS-1:0]          wren,
    input  logic [NUM_PORTS*ADDR_W-1:0]   Address,
    input  logic [NUM_PORTS*DATA_W-1:0]   Din,
    input  logic [DATA_W-1:0]             RAMq,
    output logic [NUM_PORTS-1:0]          acq,
    output logic [NUM_PORTS*DATA_W-1:0]   Dq,
    output logic [ADDR_W-1:0]             RAMAddress,
    output logic [DATA_W-1:0]             RAMDin,
    output logic                          RAMwren
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [1:0]          wait_cnt;
    logic [1:0]          wait_cnt_nxt;

    logic [NUM_PORTS-1:0] req;
    logic [PTR_W-1:0]     win;        // port owning the operation in flight
    logic [PTR_W-1:0]     win_nxt;    // arbitration result for this cycle
    logic                 op_wr;      // operation in flight is a write
    logic                 cool;       // first IDLE cycle after DONE: no grant
    logic                 grant;
    logic                 enter_done;

    assign req   = rden | wren;
    assign grant = (state == IDLE) && !cool && (|req);

    // -------------------------------------------------------------------------
    // Winner selection
    // -------------------------------------------------------------------------
`ifdef MEMARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest requesting index is assigned last.
    always_comb begin
        win_nxt = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) win_nxt = PTR_W'(i);
        end
    end
`else
    logic [PTR_W-1:0] ptr;            // last granted port

    // Candidates ptr+1 .. ptr+NUM_PORTS (mod NUM_PORTS), visited farthest
    // first so that the nearest requester after ptr ends up as the winner.
    always_comb begin
        win_nxt = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_PORTS])
                win_nxt = PTR_W'((int'(ptr) + k) % NUM_PORTS);
        end
    end

    // ptr only moves when an operation completes; reset makes port 0 the
    // first candidate.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst)
            ptr <= PTR_W'(NUM_PORTS - 1);
        else if (state == DONE)
            ptr <= win;
    end
`endif

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // WAIT_RD covers the RAM read latency: the RAM samples the address on the
    // edge leaving ISSUE, and q is captured RD_LAT edges after that.
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            IDLE: begin
                if (grant) state_nxt = ISSUE;
            end
            ISSUE: begin
                if (op_wr) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt    = WAIT_RD;
                    wait_cnt_nxt = 2'(RD_LAT - 1);
                end
            end
            WAIT_RD: begin
                if (wait_cnt == 2'd0)
                    state_nxt = DONE;
                else
                    wait_cnt_nxt = wait_cnt - 2'd1;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign enter_done = (state_nxt == DONE) && (state != DONE);

    // -------------------------------------------------------------------------
    // RAM bus, completion pulse and held read data
    // -------------------------------------------------------------------------
    // NOTE: Dq is a small register array, not a RAM, so it is cleared on reset
    // like any other flop; this keeps the outputs defined after reset.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            win        <= '0;
            op_wr      <= 1'b0;
            cool       <= 1'b0;
            acq        <= '0;
            Dq         <= '0;
            RAMAddress <= '0;
            RAMDin     <= '0;
            RAMwren    <= 1'b0;
        end else begin
            acq  <= '0;
            cool <= (state == DONE);

            // Only the winner's slices are ever looked at. A port raising
            // rden and wren together is treated as a plain write.
            if (grant) begin
                win        <= win_nxt;
                op_wr      <= wren[win_nxt];
                RAMAddress <= Address[win_nxt*ADDR_W +: ADDR_W];
                RAMDin     <= Din[win_nxt*DATA_W +: DATA_W];
                RAMwren    <= wren[win_nxt];
            end

            // The RAM samples the write during ISSUE only.
            if (state == ISSUE)
                RAMwren <= 1'b0;

            // acq and Dq become visible together for the whole DONE cycle.
            if (enter_done) begin
                acq <= NUM_PORTS'(1) << win;
                if (!op_wr)
                    Dq[win*DATA_W +: DATA_W] <= RAMq;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
module tb_mem_arbiter_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: 2 ports, RD_LAT = 1
  logic [1:0]  rden_a, wren_a, acq_a;
  logic [15:0] addr_a, din_a, dq_a;
  logic [7:0]  ramq_a, ram_addr_a, ram_din_a;
  logic        ram_wren_a;

  // Instance B: 4 ports, RD_LAT = 2
  logic [3:0]  rden_b, wren_b, acq_b;
  logic [31:0] addr_b, din_b, dq_b;
  logic [7:0]  ramq_b, ram_addr_b, ram_din_b;
  logic        ram_wren_b;

  mem_arbiter_rr #(.NUM_PORTS(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_a (
    .CLK(clk), .rst(rst), .rden(rden_a), .wren(wren_a), .Address(addr_a),
    .Din(din_a), .RAMq(ramq_a), .acq(acq_a), .Dq(dq_a),
    .RAMAddress(ram_addr_a), .RAMDin(ram_din_a), .RAMwren(ram_wren_a)
  );

  mem_arbiter_rr #(.NUM_PORTS(4), .ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u_b (
    .CLK(clk), .rst(rst), .rden(rden_b), .wren(wren_b), .Address(addr_b),
    .Din(din_b), .RAMq(ramq_b), .acq(acq_b), .Dq(dq_b),
    .RAMAddress(ram_addr_b), .RAMDin(ram_din_b), .RAMwren(ram_wren_b)
  );

  // Synchronous RAM models with 1 and 2 edges of read latency.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] q_a, q_b1, q_b2;

  always @(posedge clk) begin
    if (ram_wren_a) mem_a[ram_addr_a] <= ram_din_a;
    q_a <= mem_a[ram_addr_a];
  end

  always @(posedge clk) begin
    if (ram_wren_b) mem_b[ram_addr_b] <= ram_din_b;
    q_b1 <= mem_b[ram_addr_b];
    q_b2 <= q_b1;
  end

  assign ramq_a = q_a;
  assign ramq_b = q_b2;

  // Scoreboard: one entry per expected completion, in expected order.
  typedef struct {
    int         port;
    bit         rd;
    logic [7:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [7:0]  shadow [2][256];
  logic [31:0] exp_dq [2];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] acq_of(input bit inst);
    return inst ? acq_b : {2'b00, acq_a};
  endfunction

  function automatic logic [31:0] dq_of(input bit inst);
    return inst ? dq_b : {16'h0000, dq_a};
  endfunction

  function automatic logic [7:0] ram_addr_of(input bit inst);
    return inst ? ram_addr_b : ram_addr_a;
  endfunction

  function automatic logic [7:0] ram_din_of(input bit inst);
    return inst ? ram_din_b : ram_din_a;
  endfunction

  function automatic logic ram_wren_of(input bit inst);
    return inst ? ram_wren_b : ram_wren_a;
  endfunction

  task automatic set_req(input bit inst, input int port, input bit rd, input bit wr,
                         input logic [7:0] addr, input logic [7:0] din);
    if (inst) begin
      rden_b[port] = rd;
      wren_b[port] = wr;
      addr_b[port*8 +: 8] = addr;
      din_b[port*8 +: 8]  = din;
    end else begin
      rden_a[port] = rd;
      wren_a[port] = wr;
      addr_a[port*8 +: 8] = addr;
      din_a[port*8 +: 8]  = din;
    end
  endtask

  // Queue an expected completion and keep the shadow memory current.
  task automatic expect_op(input bit inst, input int port, input bit rd, input bit wr,
                           input logic [7:0] addr, input logic [7:0] din);
    exp_t e;
    e.port = port;
    e.rd   = rd && !wr;
    e.data = e.rd ? shadow[inst][addr] : 8'h00;
    if (wr) shadow[inst][addr] = din;
    sb.push_back(e);
  endtask

  // Called while acq is high: pop the oldest expectation and compare.
  task automatic complete(input bit inst, input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.rd) exp_dq[inst][e.port*8 +: 8] = e.data;
      check({tag, "_acq"}, 32'(acq_of(inst)), 32'(4'b0001 << e.port));
      check({tag, "_dq"}, dq_of(inst), exp_dq[inst]);
    end
  endtask

  // One isolated operation with latency, bus and pulse-width checks.
  task automatic single_op(input bit inst, input int port, input bit rd, input bit wr,
                           input logic [7:0] addr, input logic [7:0] din,
                           input int exp_lat, input string tag);
    int n;
    int wren_cycles;
    bit seen;
    expect_op(inst, port, rd, wr, addr, din);
    @(negedge clk);
    set_req(inst, port, rd, wr, addr, din);
    n = 0;
    wren_cycles = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (ram_wren_of(inst)) begin
        wren_cycles++;
        check({tag, "_wr_addr"}, 32'(ram_addr_of(inst)), 32'(addr));
        check({tag, "_wr_data"}, 32'(ram_din_of(inst)), 32'(din));
      end
      if (acq_of(inst) != 4'b0000) seen = 1'b1;
    end
    check({tag, "_acq_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_wren_cycles"}, wren_cycles, wr ? 1 : 0);
      check({tag, "_bus_addr"}, 32'(ram_addr_of(inst)), 32'(addr));
      complete(inst, tag);
    end else begin
      sb.delete();
    end
    @(negedge clk);
    set_req(inst, port, 1'b0, 1'b0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check({tag, "_acq_width"}, 32'(acq_of(inst)), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  // Watch a stream of completions from held requests.
  task automatic stream(input bit inst, input int n_acq, input logic [3:0] forbid,
                        input string tag);
    int got;
    int cyc;
    logic [3:0] stray;
    got = 0;
    cyc = 0;
    stray = 4'b0000;
    while (got < n_acq && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      stray |= acq_of(inst) & forbid;
      if (acq_of(inst) != 4'b0000) begin
        complete(inst, tag);
        got++;
      end
    end
    check({tag, "_count"}, got, n_acq);
    check({tag, "_stray"}, 32'(stray), 32'd0);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input bit inst, input string tag);
    check({tag, "_acq"},   32'(acq_of(inst)),      32'd0);
    check({tag, "_dq"},    dq_of(inst),            32'd0);
    check({tag, "_addr"},  32'(ram_addr_of(inst)), 32'd0);
    check({tag, "_din"},   32'(ram_din_of(inst)),  32'd0);
    check({tag, "_wren"},  32'(ram_wren_of(inst)), 32'd0);
  endtask

  initial begin
    logic [3:0] stray;

    rst    = 1'b1;
    rden_a = '0; wren_a = '0; addr_a = '0; din_a = '0;
    rden_b = '0; wren_b = '0; addr_b = '0; din_b = '0;
    exp_dq[0] = '0;
    exp_dq[1] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(1'b0, "rst_a");
    check_reset_outputs(1'b1, "rst_b");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Port 0 write, port 1 read back, combined rden+wren is a write.
    single_op(1'b0, 0, 1'b0, 1'b1, 8'h10, 8'hA5, 2, "t1_wr");
    single_op(1'b0, 1, 1'b1, 1'b0, 8'h10, 8'h00, 3, "t2_rd");
    single_op(1'b0, 0, 1'b1, 1'b1, 8'h20, 8'h3C, 2, "t5_rdwr");
    single_op(1'b0, 0, 1'b1, 1'b0, 8'h20, 8'h00, 3, "t5_rd");

    // Four-port instance with two-edge read latency.
    single_op(1'b1, 2, 1'b0, 1'b1, 8'h44, 8'h5A, 2, "b_wr");
    single_op(1'b1, 2, 1'b1, 1'b0, 8'h44, 8'h00, 4, "b_rd");

    // Reset while a read sits in WAIT_RD: outputs clear at once, no acq.
    @(negedge clk);
    set_req(1'b1, 2, 1'b1, 1'b0, 8'h44, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("t6_pre_addr", 32'(ram_addr_b), 32'h44);
    rst = 1'b1;
    #1;
    check_reset_outputs(1'b1, "t6_rst");
    @(negedge clk);
    set_req(1'b1, 2, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_dq[0] = '0;
    exp_dq[1] = '0;
    stray = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      stray |= acq_b;
    end
    check("t6_no_acq", 32'(stray), 32'd0);

    // Ports 0 and 1 hold read requests on the two-port instance.
`ifdef MEMARB_FIXED_PRIO_EN
    expect_op(1'b0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    expect_op(1'b0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    expect_op(1'b0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    expect_op(1'b0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
`else
    expect_op(1'b0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    expect_op(1'b0, 1, 1'b1, 1'b0, 8'h10, 8'h00);
    expect_op(1'b0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    expect_op(1'b0, 1, 1'b1, 1'b0, 8'h10, 8'h00);
`endif
    @(negedge clk);
    set_req(1'b0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
    set_req(1'b0, 1, 1'b1, 1'b0, 8'h10, 8'h00);
    stream(1'b0, 4, 4'b1100, "t3");
    @(negedge clk);
    set_req(1'b0, 0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b0, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);

    // Ports 1 and 3 hold writes on the four-port instance, pointer at 3.
`ifdef MEMARB_FIXED_PRIO_EN
    expect_op(1'b1, 1, 1'b0, 1'b1, 8'h31, 8'h11);
    expect_op(1'b1, 1, 1'b0, 1'b1, 8'h31, 8'h11);
    expect_op(1'b1, 1, 1'b0, 1'b1, 8'h31, 8'h11);
`else
    expect_op(1'b1, 1, 1'b0, 1'b1, 8'h31, 8'h11);
    expect_op(1'b1, 3, 1'b0, 1'b1, 8'h33, 8'h33);
    expect_op(1'b1, 1, 1'b0, 1'b1, 8'h31, 8'h11);
`endif
    @(negedge clk);
    set_req(1'b1, 1, 1'b0, 1'b1, 8'h31, 8'h11);
    set_req(1'b1, 3, 1'b0, 1'b1, 8'h33, 8'h33);
    stream(1'b1, 3, 4'b0101, "t4");
    @(negedge clk);
    set_req(1'b1, 1, 1'b0, 1'b0, 8'h00, 8'h00);
    set_req(1'b1, 3, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
